// File: rtl/pcis_imem_responder_if.sv
// AXI4 PCIS channel bundle between the host DMA port and pcis_imem_responder.
interface pcis_imem_responder_if #(
   parameter int ID_W   = 16,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
);
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic                arvalid;
   logic                arready;
   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport master (
      output awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arlen, arsize, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arlen, arsize, arvalid, rready,
      output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/pcis_imem_responder.sv
// Host-loadable instruction memory: AXI4 INCR slave plus a 1-cycle core fetch port.
// Define PCIS_IMEM_LOCK_EN to reject host writes whose AW arrives while run_i is high.
module pcis_imem_responder #(
   parameter int ID_W   = 16,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512,
   parameter int DEPTH  = 1024
) (
   input  logic                     clk_main_a0,
   input  logic                     rst_main,
   pcis_imem_responder_if.slave     axi,
   input  logic                     run_i,
   input  logic                     core_rd_en,
   input  logic [$clog2(DEPTH)-1:0] core_rd_addr,
   output logic [DATA_W-1:0]        core_rd_data
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH) << OFF_W;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   localparam logic [1:0] W_IDLE  = 2'd0;
   localparam logic [1:0] W_DATA  = 2'd1;
   localparam logic [1:0] W_RESP  = 2'd2;
   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_FETCH = 2'd1;
   localparam logic [1:0] R_DATA  = 2'd2;

`ifdef PCIS_IMEM_LOCK_EN
   localparam logic LOCK_EN = 1'b1;
`else
   localparam logic LOCK_EN = 1'b0;
`endif

   function automatic logic [1:0] resp_enc(input logic dec, input logic slv);
      return dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return a < MEM_BYTES;
   endfunction

   function automatic logic size_err(input logic [2:0] s);
      return int'(s) > OFF_W;
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [2:0] s);
      return a + (ADDR_W'(1) << s);
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   // Write channel
   logic [1:0]        w_state, w_state_nxt;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_len, w_cnt;
   logic [2:0]        w_size;
   logic              w_dec, w_slv, w_lock;
   logic              aw_hs, w_hs, b_hs, w_final, w_beat_ok, w_beat_slv, w_lock_req, mem_we;
   logic [IDX_W-1:0]  w_line;

   assign aw_hs      = axi.awvalid & axi.awready;
   assign w_hs       = axi.wvalid & axi.wready;
   assign b_hs       = axi.bvalid & axi.bready;
   assign w_final    = (w_cnt == w_len);
   assign w_beat_ok  = in_range(w_addr);
   assign w_beat_slv = (axi.wlast != w_final);
   assign w_lock_req = LOCK_EN & run_i;
   assign w_line     = w_addr[OFF_W +: IDX_W];
   assign mem_we     = w_hs & w_beat_ok & ~w_lock;

   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
         W_DATA:  if (w_hs && w_final) w_state_nxt = W_RESP;
         W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they stay low during reset.
   always_ff @(posedge clk_main_a0 or posedge rst_main) begin
      if (rst_main) begin
         w_state     <= W_IDLE;
         axi.awready <= 1'b0;
         axi.wready  <= 1'b0;
         axi.bvalid  <= 1'b0;
         axi.bid     <= '0;
         axi.bresp   <= RESP_OKAY;
         w_cnt       <= '0;
         w_dec       <= 1'b0;
         w_slv       <= 1'b0;
         w_lock      <= 1'b0;
      end else begin
         w_state     <= w_state_nxt;
         axi.awready <= (w_state_nxt == W_IDLE);
         axi.wready  <= (w_state_nxt == W_DATA);
         axi.bvalid  <= (w_state_nxt == W_RESP);
         if (aw_hs) begin
            axi.bid <= axi.awid;
            w_cnt   <= '0;
            w_dec   <= 1'b0;
            w_slv   <= size_err(axi.awsize) | w_lock_req;
            w_lock  <= w_lock_req;
         end
         if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            w_dec <= w_dec | ~w_beat_ok;
            w_slv <= w_slv | w_beat_slv;
            if (w_final) axi.bresp <= resp_enc(w_dec | ~w_beat_ok, w_slv | w_beat_slv);
         end
      end
   end

   always_ff @(posedge clk_main_a0) begin
      if (aw_hs) begin
         w_addr <= axi.awaddr;
         w_len  <= axi.awlen;
         w_size <= axi.awsize;
      end else if (w_hs) begin
         w_addr <= next_addr(w_addr, w_size);
      end
   end

   always_ff @(posedge clk_main_a0) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi.wstrb[b]) mem[w_line][b*8 +: 8] <= axi.wdata[b*8 +: 8];
         end
      end
   end

   // Read channel
   logic [1:0]        r_state, r_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_len, r_cnt;
   logic [2:0]        r_size;
   logic              r_slv, ar_hs, r_hs, r_beat_ok;
   logic [IDX_W-1:0]  r_line;

   assign ar_hs     = axi.arvalid & axi.arready;
   assign r_hs      = axi.rvalid & axi.rready;
   assign r_beat_ok = in_range(r_addr);
   assign r_line    = r_addr[OFF_W +: IDX_W];

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_nxt = R_FETCH;
         R_FETCH: r_state_nxt = R_DATA;
         R_DATA:  if (r_hs) r_state_nxt = axi.rlast ? R_IDLE : R_FETCH;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_main_a0 or posedge rst_main) begin
      if (rst_main) begin
         r_state     <= R_IDLE;
         axi.arready <= 1'b0;
         axi.rvalid  <= 1'b0;
         axi.rlast   <= 1'b0;
         axi.rid     <= '0;
         axi.rresp   <= RESP_OKAY;
         axi.rdata   <= '0;
         r_cnt       <= '0;
         r_slv       <= 1'b0;
      end else begin
         r_state     <= r_state_nxt;
         axi.arready <= (r_state_nxt == R_IDLE);
         axi.rvalid  <= (r_state_nxt == R_DATA);
         if (ar_hs) begin
            axi.rid <= axi.arid;
            r_cnt   <= '0;
            r_slv   <= size_err(axi.arsize);
         end
         // Fetch cycle: the beat is captured here and held until rready.
         if (r_state == R_FETCH) begin
            axi.rdata <= r_beat_ok ? mem[r_line] : '0;
            axi.rresp <= resp_enc(~r_beat_ok, r_slv);
            axi.rlast <= (r_cnt == r_len);
         end
         if (r_hs) begin
            r_cnt     <= r_cnt + 8'd1;
            axi.rlast <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_main_a0) begin
      if (ar_hs) begin
         r_addr <= axi.araddr;
         r_len  <= axi.arlen;
         r_size <= axi.arsize;
      end else if (r_hs) begin
         r_addr <= next_addr(r_addr, r_size);
      end
   end

   // Core fetch port
   always_ff @(posedge clk_main_a0 or posedge rst_main) begin
      if (rst_main) begin
         core_rd_data <= '0;
      end else if (core_rd_en) begin
         core_rd_data <= mem[core_rd_addr];
      end
   end
endmodule

// File: tb/tb_pcis_imem_responder.sv
// Self-checking bench for pcis_imem_responder: vector table of AXI bursts against a byte-level memory model.
module tb_pcis_imem_responder;
   localparam int BUDGET = 100;
`ifdef PCIS_IMEM_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         run_i = 1'b0;
   logic         core_rd_en = 1'b0;
   logic [9:0]   core_rd_addr = '0;
   logic [511:0] core_rd_data;

   pcis_imem_responder_if #(.ID_W(16), .ADDR_W(64), .DATA_W(512)) axi ();

   pcis_imem_responder #(.ID_W(16), .ADDR_W(64), .DATA_W(512), .DEPTH(1024)) dut (
      .clk_main_a0 (clk),
      .rst_main    (rst),
      .axi         (axi),
      .run_i       (run_i),
      .core_rd_en  (core_rd_en),
      .core_rd_addr(core_rd_addr),
      .core_rd_data(core_rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [63:0] strb;
      logic [31:0] base;
      bit          wlast_bad;
      bit          run;
      bit          toggle;
      logic [1:0]  exp_resp;
   } vec_t;

   typedef struct {
      logic [511:0] data;
      logic [1:0]   resp;
      logic         last;
   } rexp_t;

   vec_t         vecs [18];
   rexp_t        sb [$];
   logic [511:0] mem_m [1024];
   int           checks = 0;
   int           errors = 0;

   function automatic vec_t mkv(bit wr, logic [63:0] addr, logic [7:0] len, logic [2:0] size,
                                logic [63:0] strb, logic [31:0] base, bit wlb, bit run,
                                bit tog, logic [1:0] resp);
      vec_t v;
      v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.strb = strb; v.base = base;
      v.wlast_bad = wlb; v.run = run; v.toggle = tog; v.exp_resp = resp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no handshake within %0d cycles", name, BUDGET);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int id, input vec_t v, input int core_line);
      logic [63:0]  a;
      logic [511:0] wd, core_exp;
      int           n;
      bit           lk;
      lk = LOCK && v.run;
      core_exp = '0;
      run_i = v.run;
      axi.awid = 16'(id); axi.awaddr = v.addr; axi.awlen = v.len; axi.awsize = v.size;
      axi.awvalid = 1'b1;
      n = 0;
      while (axi.awready !== 1'b1 && n < BUDGET) begin tick(); n++; end
      if (n == BUDGET) begin
         timeout_fail($sformatf("w%0d awready", id));
         axi.awvalid = 1'b0;
         return;
      end
      tick();
      axi.awvalid = 1'b0;
      run_i = ~v.run;
      a = v.addr;
      for (int k = 0; k <= int'(v.len); k++) begin
         wd = {16{v.base + 32'(k)}};
         axi.wdata = wd; axi.wstrb = v.strb;
         axi.wlast = v.wlast_bad ? (k == 0) : (k == int'(v.len));
         axi.wvalid = 1'b1;
         if (k == int'(v.len) && core_line >= 0) begin
            core_rd_en = 1'b1;
            core_rd_addr = 10'(core_line);
            core_exp = mem_m[core_line];
         end
         n = 0;
         while (axi.wready !== 1'b1 && n < BUDGET) begin tick(); n++; end
         if (n == BUDGET) begin
            timeout_fail($sformatf("w%0d wready", id));
            axi.wvalid = 1'b0; core_rd_en = 1'b0;
            return;
         end
         tick();
         core_rd_en = 1'b0;
         if (a < 64'h10000 && !lk) begin
            for (int b = 0; b < 64; b++)
               if (v.strb[b]) mem_m[a[15:6]][b*8 +: 8] = wd[b*8 +: 8];
         end
         a = a + (64'd1 << v.size);
      end
      axi.wvalid = 1'b0;
      axi.wlast = 1'b0;
      if (core_line >= 0) chk($sformatf("w%0d core old data", id), core_rd_data, core_exp);
      axi.bready = 1'b1;
      n = 0;
      while (axi.bvalid !== 1'b1 && n < BUDGET) begin tick(); n++; end
      if (n == BUDGET) begin
         timeout_fail($sformatf("w%0d bvalid", id));
      end else begin
         chk($sformatf("w%0d bresp", id), 512'(axi.bresp), 512'(v.exp_resp));
         chk($sformatf("w%0d bid", id), 512'(axi.bid), 512'(id));
         tick();
         chk($sformatf("w%0d bvalid drop", id), 512'(axi.bvalid), 512'(0));
      end
      axi.bready = 1'b0;
      run_i = 1'b0;
   endtask

   task automatic do_read(input int id, input vec_t v);
      logic [63:0]  a;
      logic [511:0] held;
      rexp_t        e;
      int           n, cyc, got;
      bit           stalled, first;
      sb = {};
      axi.arid = 16'(id); axi.araddr = v.addr; axi.arlen = v.len; axi.arsize = v.size;
      axi.arvalid = 1'b1;
      axi.rready = 1'b0;
      n = 0;
      while (axi.arready !== 1'b1 && n < BUDGET) begin tick(); n++; end
      if (n == BUDGET) begin
         timeout_fail($sformatf("r%0d arready", id));
         axi.arvalid = 1'b0;
         return;
      end
      a = v.addr;
      for (int k = 0; k <= int'(v.len); k++) begin
         e.data = (a < 64'h10000) ? mem_m[a[15:6]] : '0;
         e.resp = (a >= 64'h10000) ? 2'd3 : ((v.size > 3'd6) ? 2'd2 : 2'd0);
         e.last = (k == int'(v.len));
         sb.push_back(e);
         a = a + (64'd1 << v.size);
      end
      tick();
      axi.arvalid = 1'b0;
      cyc = 1; got = 0; stalled = 1'b0; first = 1'b1; held = '0;
      while (got <= int'(v.len) && cyc < BUDGET) begin
         if (axi.rvalid === 1'b1) begin
            if (first) begin
               chk($sformatf("r%0d first-beat latency", id), 512'(cyc), 512'(2));
               first = 1'b0;
            end
            if (stalled) chk($sformatf("r%0d rdata held", id), axi.rdata, held);
            if (v.toggle && !stalled) begin
               axi.rready = 1'b0;
               stalled = 1'b1;
               held = axi.rdata;
            end else begin
               axi.rready = 1'b1;
               e = sb.pop_front();
               chk($sformatf("r%0d b%0d rdata", id, got), axi.rdata, e.data);
               chk($sformatf("r%0d b%0d rresp", id, got), 512'(axi.rresp), 512'(e.resp));
               chk($sformatf("r%0d b%0d rlast", id, got), 512'(axi.rlast), 512'(e.last));
               chk($sformatf("r%0d b%0d rid", id, got), 512'(axi.rid), 512'(id));
               got++;
               stalled = 1'b0;
            end
         end else begin
            if (stalled) chk($sformatf("r%0d rvalid held", id), 512'(axi.rvalid), 512'(1));
            stalled = 1'b0;
            axi.rready = 1'b0;
         end
         tick();
         cyc++;
      end
      axi.rready = 1'b0;
      if (got <= int'(v.len)) begin
         timeout_fail($sformatf("r%0d beats", id));
      end else begin
         chk($sformatf("r%0d rvalid after last", id), 512'(axi.rvalid), 512'(0));
         chk($sformatf("r%0d arready after last", id), 512'(axi.arready), 512'(1));
      end
   endtask

   task automatic core_read(input int line);
      core_rd_en = 1'b1;
      core_rd_addr = 10'(line);
      tick();
      core_rd_en = 1'b0;
      core_rd_addr = 10'(line ^ 1);
      chk($sformatf("core line %0d", line), core_rd_data, mem_m[line]);
      tick();
      chk($sformatf("core hold %0d", line), core_rd_data, mem_m[line]);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 1024; i++) mem_m[i] = '0;
      axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arvalid = 1'b0;
      axi.rready = 1'b0;

      vecs[0]  = mkv(1, 64'h0,     8'd7, 3'd6, '1,         32'h1000_0000, 0, 0, 0, 2'd0);
      vecs[1]  = mkv(1, 64'h4,     8'd0, 3'd2, 64'hF0,     32'hDEAD_BEEF, 0, 0, 0, 2'd0);
      vecs[2]  = mkv(0, 64'h0,     8'd0, 3'd6, '0,         32'h0,         0, 0, 0, 2'd0);
      vecs[3]  = mkv(1, 64'h40,    8'd3, 3'd6, '1,         32'h1,         0, 0, 0, 2'd0);
      vecs[4]  = mkv(0, 64'h40,    8'd3, 3'd6, '0,         32'h0,         0, 0, 1, 2'd0);
      vecs[5]  = mkv(1, 64'h10000, 8'd0, 3'd6, '1,         32'h5555_0000, 0, 0, 0, 2'd3);
      vecs[6]  = mkv(0, 64'h10000, 8'd0, 3'd6, '0,         32'h0,         0, 0, 0, 2'd0);
      vecs[7]  = mkv(1, 64'h80,    8'd1, 3'd6, '1,         32'h2000_0000, 1, 0, 0, 2'd2);
      vecs[8]  = mkv(0, 64'h80,    8'd1, 3'd6, '0,         32'h0,         0, 0, 1, 2'd0);
      vecs[9]  = mkv(1, 64'hFFC0,  8'd1, 3'd6, '1,         32'h3000_0000, 0, 0, 0, 2'd3);
      vecs[10] = mkv(0, 64'hFFC0,  8'd1, 3'd6, '0,         32'h0,         0, 0, 0, 2'd0);
      vecs[11] = mkv(1, 64'h100,   8'd1, 3'd7, '1,         32'h4000_0000, 0, 0, 0, 2'd2);
      vecs[12] = mkv(0, 64'h100,   8'd1, 3'd7, '0,         32'h0,         0, 0, 0, 2'd0);
      vecs[13] = mkv(1, 64'h0,     8'd0, 3'd2, 64'hF,      32'h1,         0, 1, 0, LOCK ? 2'd2 : 2'd0);
      vecs[14] = mkv(0, 64'h0,     8'd0, 3'd6, '0,         32'h0,         0, 0, 0, 2'd0);
      vecs[15] = mkv(1, 64'h0,     8'd0, 3'd2, 64'hF,      32'h2,         0, 0, 0, 2'd0);
      vecs[16] = mkv(1, 64'hC0,    8'd2, 3'd5, '1,         32'h6000_0000, 0, 0, 0, 2'd0);
      vecs[17] = mkv(0, 64'hC0,    8'd2, 3'd5, '0,         32'h0,         0, 0, 1, 2'd0);

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst awready", 512'(axi.awready), 512'(0));
      chk("rst wready",  512'(axi.wready),  512'(0));
      chk("rst arready", 512'(axi.arready), 512'(0));
      chk("rst bvalid",  512'(axi.bvalid),  512'(0));
      chk("rst rvalid",  512'(axi.rvalid),  512'(0));
      chk("rst rlast",   512'(axi.rlast),   512'(0));
      chk("rst bid",     512'(axi.bid),     512'(0));
      chk("rst rid",     512'(axi.rid),     512'(0));
      chk("rst bresp",   512'(axi.bresp),   512'(0));
      chk("rst rresp",   512'(axi.rresp),   512'(0));
      chk("rst rdata",   axi.rdata,         512'(0));
      chk("rst core_rd_data", core_rd_data, 512'(0));
      rst = 1'b0;
      tick();
      chk("post-rst awready", 512'(axi.awready), 512'(1));
      chk("post-rst arready", 512'(axi.arready), 512'(1));

      for (int i = 0; i < 18; i++) begin
         if (vecs[i].wr) do_write(i, vecs[i], -1);
         else            do_read(i, vecs[i]);
      end

      core_read(0);
      core_read(1);
      core_read(3);

      // Core read on the same edge as a write to that line sees the old contents
      do_write(20, mkv(1, 64'hC0, 8'd0, 3'd6, '1, 32'h7700_0000, 0, 0, 0, 2'd0), 3);
      core_read(3);

      // Reset while the write FSM waits for data
      axi.awid = 16'd30; axi.awaddr = 64'h200; axi.awlen = 8'd3; axi.awsize = 3'd6;
      axi.awvalid = 1'b1;
      n = 0;
      while (axi.awready !== 1'b1 && n < BUDGET) begin tick(); n++; end
      if (n == BUDGET) timeout_fail("mid-burst awready");
      tick();
      axi.awvalid = 1'b0;
      chk("mid-burst wready", 512'(axi.wready), 512'(1));
      #3 rst = 1'b1;
      #1;
      chk("async rst awready", 512'(axi.awready), 512'(0));
      chk("async rst wready",  512'(axi.wready),  512'(0));
      chk("async rst arready", 512'(axi.arready), 512'(0));
      chk("async rst bvalid",  512'(axi.bvalid),  512'(0));
      chk("async rst rvalid",  512'(axi.rvalid),  512'(0));
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rst release awready", 512'(axi.awready), 512'(1));
      do_write(31, mkv(1, 64'h200, 8'd1, 3'd6, '1, 32'h8800_0000, 0, 0, 0, 2'd0), -1);
      do_read(32, mkv(0, 64'h200, 8'd1, 3'd6, '0, 32'h0, 0, 0, 1, 2'd0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
